// File: rtl/rst_seq_ctrl_if.sv
// Request/status bundle between firmware-facing logic (master) and the
// reset sequencing controller (slave).
interface rst_seq_ctrl_if;
   logic       sw_sys_req;
   logic       sw_cpu_req;
   logic       wdt_expire;
   logic       cause_clr;
   logic       req_ack;
   logic       bus_resetn;
   logic       cpu_resetn;
   logic       busy;
   logic [3:0] cause;

   modport master (
      output sw_sys_req, sw_cpu_req, wdt_expire, cause_clr,
      input  req_ack, bus_resetn, cpu_resetn, busy, cause
   );

   modport slave (
      input  sw_sys_req, sw_cpu_req, wdt_expire, cause_clr,
      output req_ack, bus_resetn, cpu_resetn, busy, cause
   );
endinterface

// File: rtl/rst_seq_ctrl.sv
// SoC reset sequencer: staged bus-then-CPU release, software/watchdog
// resets and a sticky reset-cause vector. All outputs come from registers.
module rst_seq_ctrl #(
   parameter int BUS_HOLD  = 16,
   parameter int CPU_DELAY = 5,
   parameter int CW        = 8
) (
   input  logic           clk,
   input  logic           rstn,
   rst_seq_ctrl_if.slave  rsc
);

   typedef enum logic [1:0] {
      S_BUS_HOLD = 2'd0,
      S_CPU_HOLD = 2'd1,
      S_RUN      = 2'd2
   } state_t;

   localparam logic [CW-1:0] BUS_LAST = CW'(BUS_HOLD - 1);
   localparam logic [CW-1:0] CPU_LAST = CW'(CPU_DELAY - 1);

   state_t        state_q,  state_nxt;
   logic [CW-1:0] cnt_q,    cnt_nxt;
   logic          bus_q,    bus_nxt;
   logic          cpu_q,    cpu_nxt;
   logic          ack_q,    ack_nxt;
   logic [3:0]    cause_q,  cause_nxt;
   logic [3:0]    cause_set;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_BUS_HOLD;
         cnt_q   <= '0;
         bus_q   <= 1'b0;
         cpu_q   <= 1'b0;
         ack_q   <= 1'b0;
         cause_q <= 4'b0001;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         bus_q   <= bus_nxt;
         cpu_q   <= cpu_nxt;
         ack_q   <= ack_nxt;
         cause_q <= cause_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      bus_nxt   = bus_q;
      cpu_nxt   = cpu_q;
      ack_nxt   = 1'b0;
      cause_set = 4'b0000;

      case (state_q)
         S_BUS_HOLD: begin
            bus_nxt = 1'b0;
            cpu_nxt = 1'b0;
            // Watchdog here only records the cause; the hold keeps counting.
            if (rsc.wdt_expire) cause_set[1] = 1'b1;
            if (cnt_q == BUS_LAST) begin
               state_nxt = S_CPU_HOLD;
               cnt_nxt   = '0;
               bus_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt_q + CW'(1);
            end
         end
         S_CPU_HOLD: begin
            bus_nxt = 1'b1;
            cpu_nxt = 1'b0;
            if (rsc.wdt_expire) begin
               state_nxt    = S_BUS_HOLD;
               cnt_nxt      = '0;
               bus_nxt      = 1'b0;
               cause_set[1] = 1'b1;
            end else if (cnt_q == CPU_LAST) begin
               state_nxt = S_RUN;
               cpu_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt_q + CW'(1);
            end
         end
         S_RUN: begin
            bus_nxt = 1'b1;
            cpu_nxt = 1'b1;
            if (rsc.wdt_expire) begin
               state_nxt    = S_BUS_HOLD;
               cnt_nxt      = '0;
               bus_nxt      = 1'b0;
               cpu_nxt      = 1'b0;
               cause_set[1] = 1'b1;
            end else if (rsc.sw_sys_req) begin
               state_nxt    = S_BUS_HOLD;
               cnt_nxt      = '0;
               bus_nxt      = 1'b0;
               cpu_nxt      = 1'b0;
               ack_nxt      = 1'b1;
               cause_set[2] = 1'b1;
            end else if (rsc.sw_cpu_req) begin
               state_nxt    = S_CPU_HOLD;
               cnt_nxt      = '0;
               cpu_nxt      = 1'b0;
               ack_nxt      = 1'b1;
               cause_set[3] = 1'b1;
            end
         end
         default: begin
            state_nxt = S_BUS_HOLD;
            cnt_nxt   = '0;
            bus_nxt   = 1'b0;
            cpu_nxt   = 1'b0;
         end
      endcase

      // A set event on the same edge as a clear keeps its own bit.
      cause_nxt = (cause_q & {4{~rsc.cause_clr}}) | cause_set;
   end

   assign rsc.bus_resetn = bus_q;
   assign rsc.cpu_resetn = cpu_q;
   assign rsc.req_ack    = ack_q;
   assign rsc.busy       = (state_q != S_RUN);
   assign rsc.cause      = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with default timing (bus hold 16, CPU delay 5).
module tb_rst_seq_ctrl;
   logic clk;
   logic rstn;
   int   checks;
   int   errors;
   int   bl, cl, acks;

   rst_seq_ctrl_if rsc_if ();

   rst_seq_ctrl #(.BUS_HOLD(16), .CPU_DELAY(5), .CW(8)) dut (
      .clk  (clk),
      .rstn (rstn),
      .rsc  (rsc_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Counts samples with cpu_resetn low (and bus_resetn low, req_ack high
   // among them) from now until cpu_resetn rises; bounded at 100 cycles.
   task automatic count_low(output int b, output int c, output int a);
      b = 0; c = 0; a = 0;
      for (int i = 0; i < 100; i++) begin
         if (rsc_if.cpu_resetn) break;
         if (!rsc_if.bus_resetn) b++;
         if (rsc_if.req_ack) a++;
         c++;
         step(1);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstn = 1'b0;
      rsc_if.sw_sys_req = 1'b0;
      rsc_if.sw_cpu_req = 1'b0;
      rsc_if.wdt_expire = 1'b0;
      rsc_if.cause_clr  = 1'b0;
      step(3);

      // Reset state
      check("rst_bus",   rsc_if.bus_resetn, 0);
      check("rst_cpu",   rsc_if.cpu_resetn, 0);
      check("rst_busy",  rsc_if.busy,       1);
      check("rst_ack",   rsc_if.req_ack,    0);
      check("rst_cause", rsc_if.cause,      4'b0001);

      // POR release timing
      rstn = 1'b1;
      step(15);
      check("por_bus_e15", rsc_if.bus_resetn, 0);
      step(1);
      check("por_bus_e16", rsc_if.bus_resetn, 1);
      check("por_cpu_e16", rsc_if.cpu_resetn, 0);
      step(4);
      check("por_cpu_e20",  rsc_if.cpu_resetn, 0);
      check("por_busy_e20", rsc_if.busy,       1);
      step(1);
      check("por_cpu_e21",  rsc_if.cpu_resetn, 1);
      check("por_busy_e21", rsc_if.busy,       0);
      check("por_cause",    rsc_if.cause,      4'b0001);

      // Software CPU-only reset
      rsc_if.sw_cpu_req = 1'b1;
      step(1);
      rsc_if.sw_cpu_req = 1'b0;
      check("cpu_cause", rsc_if.cause, 4'b1001);
      count_low(bl, cl, acks);
      check("cpu_low_cycles", cl,   5);
      check("cpu_bus_low",    bl,   0);
      check("cpu_acks",       acks, 1);
      check("cpu_busy_end",   rsc_if.busy, 0);

      // Clear cause, then software system reset
      rsc_if.cause_clr = 1'b1;
      step(1);
      rsc_if.cause_clr = 1'b0;
      check("clr_cause", rsc_if.cause, 4'b0000);
      rsc_if.sw_sys_req = 1'b1;
      step(1);
      rsc_if.sw_sys_req = 1'b0;
      check("sys_cause", rsc_if.cause, 4'b0100);
      count_low(bl, cl, acks);
      check("sys_bus_low", bl,   16);
      check("sys_cpu_low", cl,   21);
      check("sys_acks",    acks, 1);

      // Watchdog and CPU request on the same edge: watchdog wins
      rsc_if.wdt_expire = 1'b1;
      rsc_if.sw_cpu_req = 1'b1;
      step(1);
      rsc_if.wdt_expire = 1'b0;
      rsc_if.sw_cpu_req = 1'b0;
      check("pri_ack",   rsc_if.req_ack,    0);
      check("pri_bus",   rsc_if.bus_resetn, 0);
      check("pri_cause", rsc_if.cause,      4'b0110);
      count_low(bl, cl, acks);
      check("pri_bus_low", bl,   16);
      check("pri_cpu_low", cl,   21);
      check("pri_acks",    acks, 0);

      // Watchdog escalates a CPU-only reset two cycles in
      rsc_if.sw_cpu_req = 1'b1;
      step(1);
      rsc_if.sw_cpu_req = 1'b0;
      check("esc_ack", rsc_if.req_ack, 1);
      step(2);
      check("esc_bus_pre", rsc_if.bus_resetn, 1);
      rsc_if.wdt_expire = 1'b1;
      step(1);
      rsc_if.wdt_expire = 1'b0;
      check("esc_bus", rsc_if.bus_resetn, 0);
      check("esc_cause", rsc_if.cause, 4'b1110);
      count_low(bl, cl, acks);
      check("esc_bus_low", bl, 16);
      check("esc_cpu_low", cl, 21);

      // Asynchronous rstn in the middle of a CPU hold
      rsc_if.sw_cpu_req = 1'b1;
      step(1);
      rsc_if.sw_cpu_req = 1'b0;
      step(2);
      check("mid_bus_pre", rsc_if.bus_resetn, 1);
      check("mid_cpu_pre", rsc_if.cpu_resetn, 0);
      rstn = 1'b0;
      #2;
      check("mid_bus",   rsc_if.bus_resetn, 0);
      check("mid_cpu",   rsc_if.cpu_resetn, 0);
      check("mid_busy",  rsc_if.busy,       1);
      check("mid_cause", rsc_if.cause,      4'b0001);
      step(2);
      rstn = 1'b1;
      count_low(bl, cl, acks);
      check("rel_bus_low", bl, 16);
      check("rel_cpu_low", cl, 21);
      check("rel_cause",   rsc_if.cause, 4'b0001);
      check("rel_busy",    rsc_if.busy,  0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset sequencing controller for the SoC reset tree. It stages release of the bus reset and then the CPU reset after rstn deasserts. It also services software-requested CPU-only and full-system resets and watchdog-forced system resets, and records a sticky reset-cause vector for firmware. It replaces ad-hoc GPIO-driven reset control with a single FSM whose outputs are all registered.

Parameters:
BUS_HOLD, 16, cycles bus_resetn is held low after entering the bus-hold phase (legal range 1..2^CW-1)
CPU_DELAY, 5, cycles cpu_resetn is held low after bus_resetn releases (legal range 1..2^CW-1)
CW, 8, width of the internal phase counter

Ports:
clk  input  1  system clock; all state changes on its rising edge
rstn  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is taken on the next rising edge of clk
sw_sys_req  input  1  level; firmware request for a full-system reset
sw_cpu_req  input  1  level; firmware request for a CPU-only reset
wdt_expire  input  1  level/pulse; watchdog timeout
cause_clr  input  1  one-cycle strobe; clears the reset-cause vector
req_ack  output  1  one-cycle pulse; a software request was accepted
bus_resetn  output  1  registered active-low bus/peripheral reset
cpu_resetn  output  1  registered active-low CPU reset
busy  output  1  high whenever state is not S_RUN
cause  output  4  sticky cause bits: [0] POR, [1] WDT, [2] SW_SYS, [3] SW_CPU

Behaviour:
- States: S_BUS_HOLD, S_CPU_HOLD, S_RUN. The counter cnt is CW bits wide.
- While rstn is low: state=S_BUS_HOLD, cnt=0, bus_resetn=0, cpu_resetn=0, req_ack=0, busy=1, cause=4'b0001.
- S_BUS_HOLD: bus_resetn=0, cpu_resetn=0.
  - If cnt==BUS_HOLD-1: go to S_CPU_HOLD, set cnt=0, and register bus_resetn<=1.
  - Otherwise: cnt++.
- S_CPU_HOLD: bus_resetn=1, cpu_resetn=0.
  - If cnt==CPU_DELAY-1: go to S_RUN and register cpu_resetn<=1.
  - Otherwise: cnt++.
- Release timing from rstn deassertion, counting the first rising edge with rstn high as edge 1:
  - bus_resetn goes high after edge BUS_HOLD.
  - cpu_resetn goes high after edge BUS_HOLD+CPU_DELAY.
- S_RUN: both reset outputs high. Events are sampled each edge with fixed priority wdt_expire > sw_sys_req > sw_cpu_req.
  - wdt_expire: go to S_BUS_HOLD, cnt=0, bus_resetn<=0, cpu_resetn<=0, set cause[1]. No ack.
  - sw_sys_req: same transition as wdt_expire, set cause[2], req_ack=1 for one cycle.
  - sw_cpu_req: go to S_CPU_HOLD, cnt=0, cpu_resetn<=0 (bus_resetn stays high), set cause[3], req_ack=1 for one cycle.
  - Outputs change on the same edge that samples the request, so they are visible one cycle later.
- wdt_expire in S_CPU_HOLD escalates: go to S_BUS_HOLD, cnt=0, bus_resetn<=0, set cause[1].
- wdt_expire in S_BUS_HOLD sets cause[1] only; cnt is not restarted.
- sw_sys_req and sw_cpu_req outside S_RUN are ignored: no ack, no cause update.
- Firmware must drop a request after seeing req_ack. A request still held high when the FSM re-enters S_RUN is accepted again.
- Cause vector: bits accumulate (OR) and are never cleared by a software or watchdog reset. cause_clr clears all bits; a set event on the same edge wins for its own bit.
- req_ack is 0 in every cycle except the acceptance cycle.
- Glitch-free requirement: no combinational path from any input to bus_resetn, cpu_resetn or req_ack.
- Asserting rstn mid-sequence forces the reset values immediately (asynchronously), including cause=4'b0001.

Test Plan:
- POR, BUS_HOLD=16, CPU_DELAY=5: deassert rstn → bus_resetn high after edge 16, cpu_resetn high after edge 21; busy low from edge 21; cause=0001.
- In S_RUN assert sw_cpu_req for 1 cycle → req_ack pulses once; cpu_resetn low for exactly 5 cycles; bus_resetn stays high; cause=1001.
- cause_clr, then sw_sys_req → bus_resetn low for 16 cycles, cpu_resetn low for 21; cause=0100; single req_ack.
- In S_RUN assert wdt_expire and sw_cpu_req on the same edge → system reset path taken, no req_ack, cause[1]=1, cause[3]=0.
- wdt_expire asserted 2 cycles into a CPU-only reset → bus_resetn drops on the next edge; full 16+5 sequence follows.
- Assert rstn at the midpoint of S_CPU_HOLD → bus_resetn and cpu_resetn go low without waiting for clk; cause=0001; normal POR timing on release.
